// File: rtl/ofdm_sc_mapper.sv
// ofdm_sc_mapper: places preamble and data samples onto 64 IFFT bins, zero-filling null bins.
// Define PILOT_INS_EN to insert fixed pilots on bins 7/21/43/57 of data symbols.
module ofdm_sc_mapper #(
  parameter logic [15:0] LP_P     = 16'h3fff,
  parameter logic [15:0] LP_N     = 16'hc001,
  parameter logic [51:0] LP_SIGN  = 52'h0A605302B3EA6,
  parameter int          LTS_REPS = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAD, S_END} state_t;
  state_t      state_q, state_d;
  logic [5:0]  bin_q, bin_d, car_q, car_d, bin_inc, car_inc;
  logic [1:0]  rep_q, rep_d;
  logic [31:0] dat_q, dat_d, pil_dat;
  logic        stb_q, stb_d, cyc_o_q, cyc_o_d, cyc_i_q, eof_q, eof_d;
  logic        datin_val, adv, istart, used, pil, take;
  logic [15:0] pil_v;
`ifdef PILOT_INS_EN
  always_comb begin
    pil   = (bin_q == 6'd7) | (bin_q == 6'd21) | (bin_q == 6'd43) | (bin_q == 6'd57);
    pil_v = (bin_q == 6'd57) ? LP_N : LP_P;
  end
`else
  always_comb begin
    pil   = 1'b0;
    pil_v = 16'h0;
  end
`endif
  always_comb begin
    datin_val = WE_I & STB_I & CYC_I;
    adv       = ~(stb_q & ~ACK_I);
    istart    = CYC_I & ~cyc_i_q;
    used      = (bin_q != 6'd0) & ((bin_q < 6'd27) | (bin_q > 6'd37));
    take      = used & ~pil;
    pil_dat   = pil ? {16'h0, pil_v} : 32'h0;
    bin_inc   = bin_q + 6'd1;
    car_inc   = (bin_q == 6'd63) ? 6'd0 : car_q + {5'd0, used};
    ACK_O     = datin_val & adv & (state_q == S_DATA) & take & ~eof_q;
    state_d   = state_q;
    bin_d     = bin_q;
    car_d     = car_q;
    rep_d     = rep_q;
    dat_d     = dat_q;
    stb_d     = stb_q;
    cyc_o_d   = cyc_o_q;
    // a falling CYC_I is remembered so a halted output cannot miss the end of frame
    eof_d     = (state_q == S_IDLE) ? 1'b0 : eof_q | (cyc_i_q & ~CYC_I);
    if (adv) begin
      case (state_q)
        S_IDLE: begin
          stb_d = 1'b0;
          if (istart) begin
            state_d = S_PRE;
            cyc_o_d = 1'b1;
            bin_d   = 6'd0;
            car_d   = 6'd0;
            rep_d   = 2'd0;
          end
        end
        S_PRE: begin
          stb_d = 1'b1;
          dat_d = used ? {16'h0, LP_SIGN[car_q] ? LP_N : LP_P} : 32'h0;
          bin_d = bin_inc;
          car_d = car_inc;
          if (bin_q == 6'd63) begin
            rep_d = rep_q + 2'd1;
            if (rep_q == 2'(LTS_REPS - 1)) state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (eof_q | ~CYC_I) begin
            stb_d   = 1'b0;
            state_d = (bin_q != 6'd0) ? S_PAD : S_END;
          end else if (~take | datin_val) begin
            stb_d = 1'b1;
            dat_d = take ? DAT_I : pil_dat;
            bin_d = bin_inc;
            car_d = car_inc;
          end else begin
            stb_d = 1'b0;
          end
        end
        S_PAD: begin
          stb_d = 1'b1;
          dat_d = pil_dat;
          bin_d = bin_inc;
          car_d = car_inc;
          if (bin_q == 6'd63) state_d = S_END;
        end
        S_END: begin
          stb_d   = 1'b0;
          cyc_o_d = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      bin_q   <= 6'd0;
      car_q   <= 6'd0;
      rep_q   <= 2'd0;
      dat_q   <= 32'h0;
      stb_q   <= 1'b0;
      cyc_o_q <= 1'b0;
      cyc_i_q <= 1'b1;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      car_q   <= car_d;
      rep_q   <= rep_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      cyc_o_q <= cyc_o_d;
      cyc_i_q <= CYC_I;
      eof_q   <= eof_d;
    end
  end
  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign CYC_O = cyc_o_q;
  assign WE_O  = cyc_o_q;
endmodule

// File: tb/tb_ofdm_sc_mapper.sv
// tb_ofdm_sc_mapper: directed checks of preamble, data mapping, output stall, early frame end and async reset.
module tb_ofdm_sc_mapper;
  logic        CLK_I = 1'b0, RST_I = 1'b1, WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0, ACK_I = 1'b1;
  logic [31:0] DAT_I = 32'h0;
  logic        ACK_O, CYC_O, STB_O, WE_O;
  logic [31:0] DAT_O;
  logic [31:0] out_q[$];
  int          ack_n = 0, n_assert = 0, n_fail = 0;

  ofdm_sc_mapper dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I),
    .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  always @(negedge CLK_I) begin
    if (STB_O && ACK_I) out_q.push_back(DAT_O);
    if (ACK_O) ack_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int t = 0;
    DAT_I = d; WE_I = 1'b1; STB_I = 1'b1;
    do begin @(negedge CLK_I); t++; end while (!ACK_O && t < 300);
    chk("send_ack", {31'd0, ACK_O}, 32'd1);
    @(posedge CLK_I); #1;
  endtask

  task automatic wait_size(input int n);
    int t = 0;
    while (out_q.size() < n && t < 1000) begin @(posedge CLK_I); #2; t++; end
    chk("out_count", {31'd0, out_q.size() >= n}, 32'd1);
  endtask

  function automatic int car_of(input int b);
    return (b == 0 || (b >= 27 && b <= 37)) ? -1 : (b < 27 ? b - 1 : b - 12);
  endfunction

  initial begin
    int t, c;
    repeat (2) @(posedge CLK_I);
    #1;
    chk("rst_dat", DAT_O, 32'h0);
    chk("rst_stb", {31'd0, STB_O}, 32'd0);
    chk("rst_cyc", {31'd0, CYC_O}, 32'd0);
    chk("rst_ack", {31'd0, ACK_O}, 32'd0);
    RST_I = 1'b0;
    @(posedge CLK_I); #1;
    CYC_I = 1'b1; WE_I = 1'b1; STB_I = 1'b1; DAT_I = 32'h0001_0001;
    @(posedge CLK_I); #2;
    chk("cyc_o_up", {31'd0, CYC_O}, 32'd1);
    chk("we_o", {31'd0, WE_O}, 32'd1);
    wait_size(128);
    chk("pre_no_ack", ack_n, 32'd0);
    chk("pre_b0", out_q[0], 32'h0);
    chk("pre_b1", out_q[1], 32'h0000_3fff);
    chk("pre_b2", out_q[2], 32'h0000_c001);
    chk("pre_b3", out_q[3], 32'h0000_c001);
    chk("pre_b27", out_q[27], 32'h0);
    chk("pre_b37", out_q[37], 32'h0);
    chk("pre_b38", out_q[38], 32'h0000_3fff);
    chk("pre2_b1", out_q[65], 32'h0000_3fff);
    chk("pre2_b2", out_q[66], 32'h0000_c001);
    for (int k = 1; k <= 52; k++) send({16'(k), 16'(k)});
    wait_size(192);
    chk("sym1_ack", ack_n, 32'd52);
    chk("sym1_b0", out_q[128], 32'h0);
    chk("sym1_b1", out_q[129], 32'h0001_0001);
    chk("sym1_b26", out_q[154], 32'h001a_001a);
    chk("sym1_b30", out_q[158], 32'h0);
    chk("sym1_b38", out_q[166], 32'h001b_001b);
    chk("sym1_b63", out_q[191], 32'h0034_0034);
    for (int k = 1; k <= 20; k++) send(32'h0100_0000 + k);
    ACK_I = 1'b0; DAT_I = 32'h0100_0015;
    repeat (5) begin
      @(negedge CLK_I);
      chk("halt_dat", DAT_O, 32'h0100_0014);
      chk("halt_stb", {31'd0, STB_O}, 32'd1);
      chk("halt_ack", {31'd0, ACK_O}, 32'd0);
    end
    @(posedge CLK_I); #1;
    ACK_I = 1'b1;
    for (int k = 21; k <= 52; k++) send(32'h0100_0000 + k);
    for (int k = 1; k <= 10; k++) send(32'h0200_0000 + k);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    t = 0;
    while (CYC_O && t < 300) begin @(negedge CLK_I); t++; end
    chk("cyc_o_down", {31'd0, CYC_O}, 32'd0);
    @(negedge CLK_I);
    chk("total_out", out_q.size(), 32'd320);
    chk("total_ack", ack_n, 32'd114);
    for (int b = 0; b < 64; b++) begin
      c = car_of(b);
      chk($sformatf("sym2_b%0d", b), out_q[192 + b], c < 0 ? 32'h0 : 32'h0100_0001 + c);
      chk($sformatf("sym3_b%0d", b), out_q[256 + b], (c < 0 || b > 10) ? 32'h0 : 32'h0200_0001 + c);
    end
    @(posedge CLK_I); #1;
    CYC_I = 1'b1;
    t = 0;
    while (DAT_O == 32'h0 && t < 300) begin @(negedge CLK_I); t++; end
    chk("pre_busy", DAT_O, 32'h0000_3fff);
    @(posedge CLK_I); #3;
    RST_I = 1'b1;
    #1;
    chk("arst_dat", DAT_O, 32'h0);
    chk("arst_stb", {31'd0, STB_O}, 32'd0);
    chk("arst_cyc", {31'd0, CYC_O}, 32'd0);
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
